// File: rtl/gg_cmd_pkg.sv
// Shared opcodes, payload lengths and types for the geometry command sequencer.
package gg_cmd_pkg;

    localparam logic [7:0] OP_MATRIX_MODE = 8'h10;
    localparam logic [7:0] OP_LOAD_MATRIX = 8'h13;
    localparam logic [7:0] OP_VERTEX      = 8'h03;
    localparam logic [7:0] OP_END         = 8'hFF;

    localparam int unsigned MAT_WORDS = 16;
    localparam int unsigned VTX_WORDS = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_OP,
        ST_DECODE,
        ST_LOAD_MAT,
        ST_LOAD_VTX,
        ST_EMIT_VTX,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef logic [1:0] mat_sel_t;

endpackage

// File: rtl/gg_cmd_fetch.sv
// Command BRAM read port: word pointer, remaining-word count and read-data-valid flag.
module gg_cmd_fetch
    import gg_cmd_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  cmd_words,
    input  logic              issue,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LEN_W-1:0]  rem,
    output logic              rvalid
);

    logic [ADDR_W-1:0] ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            rem    <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= issue;
            if (load) begin
                ptr <= {base_addr[ADDR_W-1:2], 2'b00};
                rem <= cmd_words;
            end else if (issue) begin
                ptr <= ptr + ADDR_W'(4);
                rem <= rem - LEN_W'(1);
            end
        end
    end

    assign mem_en   = issue;
    assign mem_addr = ptr;

endmodule

// File: rtl/gg_cmd_sequencer.sv
// Command stream decoder feeding the matrix register file and the transform stage.
// Optional statistics counters are enabled with GG_CMD_STATS_EN.
module gg_cmd_sequencer
    import gg_cmd_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  cmd_words,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              mat_we,
    output mat_sel_t          mat_sel,
    output logic [3:0]        mat_idx,
    output logic [31:0]       mat_wdata,
    output logic              vtx_valid,
    input  logic              vtx_ready,
    output logic [31:0]       vtx_x,
    output logic [31:0]       vtx_y,
    output logic [31:0]       vtx_z,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
`ifdef GG_CMD_STATS_EN
    ,
    output logic [15:0]       stat_vtx,
    output logic [15:0]       stat_mat
`endif
);

    state_t           state, state_nx;
    logic [3:0]       cnt;
    logic             issue, load, set_err, rvalid;
    logic [LEN_W-1:0] rem;
    logic [7:0]       opcode;

    assign opcode = mem_rdata[7:0];

    gg_cmd_fetch #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) u_fetch (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .base_addr(base_addr),
        .cmd_words(cmd_words),
        .issue    (issue),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .rem      (rem),
        .rvalid   (rvalid)
    );

    // Payload reads are issued from DECODE onward so each element arrives one per cycle.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        load     = 1'b0;
        set_err  = 1'b0;
        mat_we   = 1'b0;
        case (state)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = (cmd_words == '0) ? ST_DONE : ST_FETCH_OP;
                end
            end
            ST_FETCH_OP: begin
                if (rem == '0) begin
                    state_nx = ST_DONE;
                end else begin
                    issue    = 1'b1;
                    state_nx = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_MATRIX_MODE: state_nx = ST_FETCH_OP;
                    OP_LOAD_MATRIX: begin
                        if (rem >= LEN_W'(MAT_WORDS)) begin
                            issue    = 1'b1;
                            state_nx = ST_LOAD_MAT;
                        end else begin
                            set_err  = 1'b1;
                            state_nx = ST_ERR;
                        end
                    end
                    OP_VERTEX: begin
                        if (rem >= LEN_W'(VTX_WORDS)) begin
                            issue    = 1'b1;
                            state_nx = ST_LOAD_VTX;
                        end else begin
                            set_err  = 1'b1;
                            state_nx = ST_ERR;
                        end
                    end
                    OP_END:  state_nx = ST_DONE;
                    default: begin
                        set_err  = 1'b1;
                        state_nx = ST_ERR;
                    end
                endcase
            end
            ST_LOAD_MAT: begin
                mat_we = rvalid;
                issue  = (cnt != 4'(MAT_WORDS - 1));
                if (rvalid && cnt == 4'(MAT_WORDS - 1)) state_nx = ST_FETCH_OP;
            end
            ST_LOAD_VTX: begin
                issue = (cnt != 4'(VTX_WORDS - 1));
                if (rvalid && cnt == 4'(VTX_WORDS - 1)) state_nx = ST_EMIT_VTX;
            end
            ST_EMIT_VTX: begin
                if (vtx_ready) state_nx = ST_FETCH_OP;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mat_sel  <= '0;
            vtx_x    <= '0;
            vtx_y    <= '0;
            vtx_z    <= '0;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            state <= state_nx;
            if (state != state_nx) begin
                cnt <= '0;
            end else if ((state == ST_LOAD_MAT || state == ST_LOAD_VTX) && rvalid) begin
                cnt <= cnt + 4'd1;
            end
            if (state == ST_DECODE && opcode == OP_MATRIX_MODE) mat_sel <= mem_rdata[9:8];
            if (state == ST_LOAD_VTX && rvalid) begin
                case (cnt)
                    4'd0:    vtx_x <= mem_rdata;
                    4'd1:    vtx_y <= mem_rdata;
                    default: vtx_z <= mem_rdata;
                endcase
            end
            // ptr has already stepped past the opcode when DECODE flags an error.
            if (load) begin
                err      <= 1'b0;
                err_addr <= '0;
            end else if (set_err) begin
                err      <= 1'b1;
                err_addr <= mem_addr - ADDR_W'(4);
            end
        end
    end

`ifdef GG_CMD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || load) begin
            stat_vtx <= '0;
            stat_mat <= '0;
        end else begin
            if (vtx_valid && vtx_ready && stat_vtx != '1) stat_vtx <= stat_vtx + 16'd1;
            if (state == ST_LOAD_MAT && rvalid && cnt == 4'(MAT_WORDS - 1) && stat_mat != '1)
                stat_mat <= stat_mat + 16'd1;
        end
    end
`endif

    assign mat_idx   = (state == ST_LOAD_MAT) ? cnt : '0;
    assign mat_wdata = mat_we ? mem_rdata : '0;
    assign vtx_valid = (state == ST_EMIT_VTX);
    assign done      = (state == ST_DONE);
    assign busy      = (state == ST_FETCH_OP) || (state == ST_DECODE) || (state == ST_LOAD_MAT) ||
                       (state == ST_LOAD_VTX) || (state == ST_EMIT_VTX);

endmodule

// File: tb/tb_gg_cmd_sequencer.sv
// Scoreboard bench for gg_cmd_sequencer: a stream-walking model fills expectation queues,
// a negedge monitor pops them as the DUT emits reads, matrix writes, vertices and done/err.
module tb_gg_cmd_sequencer;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst, start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  cmd_words;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata = '0;
    logic              mat_we;
    logic [1:0]        mat_sel;
    logic [3:0]        mat_idx;
    logic [31:0]       mat_wdata;
    logic              vtx_valid;
    logic              vtx_ready = 1'b1;
    logic [31:0]       vtx_x, vtx_y, vtx_z;
    logic              busy, done, err;
    logic [ADDR_W-1:0] err_addr;
`ifdef GG_CMD_STATS_EN
    logic [15:0]       stat_vtx, stat_mat;
`endif

    always #5 clk = ~clk;

    gg_cmd_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .cmd_words(cmd_words),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mat_we(mat_we), .mat_sel(mat_sel), .mat_idx(mat_idx), .mat_wdata(mat_wdata),
        .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
        .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z),
        .busy(busy), .done(done), .err(err), .err_addr(err_addr)
`ifdef GG_CMD_STATS_EN
        , .stat_vtx(stat_vtx), .stat_mat(stat_mat)
`endif
    );

    logic [31:0] mem [256];
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr[9:2]];

    typedef struct { logic [1:0] sel; logic [3:0] idx; logic [31:0] data; } mat_t;
    typedef struct { logic [31:0] x; logic [31:0] y; logic [31:0] z; } vtx_t;
    typedef struct { bit is_err; logic [31:0] addr; } end_t;

    logic [31:0] exp_addr[$];
    mat_t        exp_mat[$];
    vtx_t        exp_vtx[$];
    end_t        exp_end[$];

    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;   // 0 always ready, 1 random, 2 stall five cycles
    int   hold = 0;
    bit   finished = 1'b0;
    logic [1:0] m_sel = 2'd0;
    int   exp_nv = 0;
    int   exp_nm = 0;

    localparam logic [31:0] FLT [16] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
        32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
        32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an output event, want none pending", name);
    endtask

    // Reference: walk the stream word by word applying the packet rules.
    task automatic gen_expect(input logic [31:0] base, input int unsigned n);
        logic [31:0] a0, a, word;
        logic [31:0] c [3];
        int unsigned w;
        bit fin;
        mat_t m; vtx_t v; end_t e;
        a0 = {base[31:2], 2'b00};
        w = 0; fin = 1'b0; exp_nv = 0; exp_nm = 0;
        while (!fin) begin
            a = a0 + 32'(4 * w);
            if (w == n) begin
                e.is_err = 1'b0; e.addr = '0; exp_end.push_back(e); fin = 1'b1;
            end else begin
                word = mem[a[9:2]];
                exp_addr.push_back(a);
                w++;
                case (word[7:0])
                    8'h10: m_sel = word[9:8];
                    8'h13: begin
                        if (n - w < 16) begin
                            e.is_err = 1'b1; e.addr = a; exp_end.push_back(e); fin = 1'b1;
                        end else begin
                            for (int unsigned i = 0; i < 16; i++) begin
                                a = a0 + 32'(4 * w);
                                exp_addr.push_back(a);
                                m.sel = m_sel; m.idx = 4'(i); m.data = mem[a[9:2]];
                                exp_mat.push_back(m);
                                w++;
                            end
                            exp_nm++;
                        end
                    end
                    8'h03: begin
                        if (n - w < 3) begin
                            e.is_err = 1'b1; e.addr = a; exp_end.push_back(e); fin = 1'b1;
                        end else begin
                            for (int unsigned i = 0; i < 3; i++) begin
                                a = a0 + 32'(4 * w);
                                exp_addr.push_back(a);
                                c[i] = mem[a[9:2]];
                                w++;
                            end
                            v.x = c[0]; v.y = c[1]; v.z = c[2];
                            exp_vtx.push_back(v);
                            exp_nv++;
                        end
                    end
                    8'hFF: begin
                        e.is_err = 1'b0; e.addr = '0; exp_end.push_back(e); fin = 1'b1;
                    end
                    default: begin
                        e.is_err = 1'b1; e.addr = a; exp_end.push_back(e); fin = 1'b1;
                    end
                endcase
            end
        end
    endtask

    initial begin : monitor
        int run;
        logic prev_err;
        vtx_t pv, v;
        mat_t m;
        end_t e;
        run = 0; prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0; hold = 0; prev_err = 1'b0;
            end else begin
                if (mem_en) begin
                    if (exp_addr.size() == 0) unexpected("rd_unexp");
                    else chk("rd_addr", mem_addr, exp_addr.pop_front());
                end
                if (mat_we) begin
                    run++;
                    if (exp_mat.size() == 0) unexpected("mat_unexp");
                    else begin
                        m = exp_mat.pop_front();
                        chk("mat_sel", 32'(mat_sel), 32'(m.sel));
                        chk("mat_idx", 32'(mat_idx), 32'(m.idx));
                        chk("mat_data", mat_wdata, m.data);
                    end
                end else begin
                    if (run != 0) chk("mat_run", 32'(run), 32'd16);
                    run = 0;
                end
                if (vtx_valid) begin
                    chk("vtx_no_rd", 32'(mem_en), 32'd0);
                    if (hold > 0) begin
                        chk("vtx_hold_x", vtx_x, pv.x);
                        chk("vtx_hold_y", vtx_y, pv.y);
                        chk("vtx_hold_z", vtx_z, pv.z);
                    end
                    pv.x = vtx_x; pv.y = vtx_y; pv.z = vtx_z;
                    hold++;
                    if (vtx_ready) begin
                        if (exp_vtx.size() == 0) unexpected("vtx_unexp");
                        else begin
                            v = exp_vtx.pop_front();
                            chk("vtx_x", vtx_x, v.x);
                            chk("vtx_y", vtx_y, v.y);
                            chk("vtx_z", vtx_z, v.z);
                        end
                        if (ready_mode == 2) chk("stall_len", 32'(hold), 32'd6);
                        hold = 0;
                    end
                end else begin
                    hold = 0;
                end
                if (done || (err && !prev_err)) begin
                    if (exp_end.size() == 0) unexpected("end_unexp");
                    else begin
                        e = exp_end.pop_front();
                        chk("end_kind", 32'(err), 32'(e.is_err));
                        if (e.is_err) chk("err_addr", err_addr, e.addr);
                        chk("end_busy", 32'(busy), 32'd0);
                        chk("end_vtx_valid", 32'(vtx_valid), 32'd0);
                    end
                    finished = 1'b1;
                end
                prev_err = err;
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       vtx_ready = 1'($urandom_range(0, 1));
                2:       vtx_ready = (hold >= 5);
                default: vtx_ready = 1'b1;
            endcase
        end
    end

    task automatic check_zero();
        chk("z_mem_en", 32'(mem_en), 32'd0);
        chk("z_mem_addr", mem_addr, 32'd0);
        chk("z_mat_we", 32'(mat_we), 32'd0);
        chk("z_mat_sel", 32'(mat_sel), 32'd0);
        chk("z_mat_idx", 32'(mat_idx), 32'd0);
        chk("z_mat_wdata", mat_wdata, 32'd0);
        chk("z_vtx_valid", 32'(vtx_valid), 32'd0);
        chk("z_vtx_xyz", vtx_x | vtx_y | vtx_z, 32'd0);
        chk("z_busy", 32'(busy), 32'd0);
        chk("z_done", 32'(done), 32'd0);
        chk("z_err", 32'(err), 32'd0);
        chk("z_err_addr", err_addr, 32'd0);
`ifdef GG_CMD_STATS_EN
        chk("z_stats", 32'({stat_vtx, stat_mat}), 32'd0);
`endif
    endtask

    task automatic run(input logic [31:0] base, input int unsigned n, input bit busy_start);
        int unsigned c;
        gen_expect(base, n);
        finished = 1'b0;
        @(posedge clk); #1;
        base_addr = base; cmd_words = 16'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("err_clr", 32'(err), 32'd0);
        if (n == 0) chk("zero_done", 32'(done), 32'd1);
        else begin
            chk("first_rd", 32'(mem_en), 32'd1);
            chk("busy_hi", 32'(busy), 32'd1);
        end
        if (busy_start) begin
            repeat (3) @(negedge clk);
            @(posedge clk); #1;
            base_addr = 32'h3F0; cmd_words = 16'd5; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        c = 0;
        while (!finished && c < 4000) begin
            @(negedge clk);
            c++;
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL run_timeout: got no done/err after %0d cycles, want completion", c);
        end
        repeat (2) @(negedge clk);
        chk("q_empty", 32'(exp_addr.size() + exp_mat.size() + exp_vtx.size() + exp_end.size()), 32'd0);
        chk("mat_sel_end", 32'(mat_sel), 32'(m_sel));
`ifdef GG_CMD_STATS_EN
        chk("stat_vtx", 32'(stat_vtx), 32'(exp_nv));
        chk("stat_mat", 32'(stat_mat), 32'(exp_nm));
`endif
        exp_addr.delete(); exp_mat.delete(); exp_vtx.delete(); exp_end.delete();
    endtask

    task automatic gen_random(output logic [31:0] base, output int unsigned n);
        int unsigned bw, w, np, kind;
        logic [31:0] r;
        logic [7:0] op;
        bw = $urandom_range(0, 127); w = 0; np = $urandom_range(1, 6);
        for (int unsigned p = 0; p < np; p++) begin
            kind = $urandom_range(0, 9);
            r = $urandom;
            if (kind < 2) op = 8'h10;
            else if (kind < 4) op = 8'h13;
            else if (kind < 8) op = 8'h03;
            else if (kind == 8) begin
                op = r[7:0];
                if (op == 8'h10 || op == 8'h13 || op == 8'h03 || op == 8'hFF) op = 8'h42;
            end else op = 8'hFF;
            mem[8'(bw + w)] = {r[31:8], op};
            w++;
            if (op == 8'h13) for (int unsigned i = 0; i < 16; i++) begin mem[8'(bw + w)] = $urandom; w++; end
            if (op == 8'h03) for (int unsigned i = 0; i < 3; i++) begin mem[8'(bw + w)] = $urandom; w++; end
        end
        n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w) : w;
        base = 32'(bw << 2) | 32'($urandom_range(0, 3));
    endtask

    initial begin : main
        logic [31:0] rb;
        int unsigned rn, c;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1; start = 1'b0; base_addr = '0; cmd_words = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero();

        // Full matrix load, with a start pulse while busy that must be ignored.
        mem[0] = 32'h80001013;
        for (int i = 0; i < 16; i++) mem[1 + i] = FLT[i];
        run(32'h0, 17, 1'b1);

        // Two MATRIX_MODE packets then END.
        mem[64] = 32'h00000010; mem[65] = 32'h00000110; mem[66] = 32'h000000FF;
        run(32'h100, 3, 1'b0);

        // Vertex with downstream stalled five cycles.
        mem[128] = 32'h00000003; mem[129] = 32'h3F800000; mem[130] = 32'h41200000; mem[131] = 32'h3F800000;
        ready_mode = 2;
        run(32'h200, 4, 1'b0);
        ready_mode = 0;

        // Truncated vertex, then illegal opcode (its start clears the earlier err).
        mem[192] = 32'h00000003; mem[193] = 32'h11111111; mem[194] = 32'h22222222;
        run(32'h300, 3, 1'b0);
        mem[16] = 32'h00000042; mem[17] = 32'h000000FF;
        run(32'h40, 2, 1'b0);

        run(32'h80, 0, 1'b0);

        ready_mode = 1;
        for (int k = 0; k < 40; k++) begin
            gen_random(rb, rn);
            run(rb, rn, 1'b0);
        end
        ready_mode = 0;

        // Reset in the middle of a matrix load.
        mem[0] = 32'h00000013;
        for (int i = 0; i < 16; i++) mem[1 + i] = $urandom;
        gen_expect(32'h0, 17);
        @(posedge clk); #1;
        base_addr = '0; cmd_words = 16'd17; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (!(mat_we && mat_idx == 4'd7) && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("rst_reach_idx7", 32'(mat_idx), 32'd7);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero();
        exp_addr.delete(); exp_mat.delete(); exp_vtx.delete(); exp_end.delete();
        m_sel = 2'd0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'({mem_en, busy, mat_we}), 32'd0);

        // Two vertices and one matrix in one stream.
        mem[32] = 32'hABCDEF03; mem[33] = 32'h1; mem[34] = 32'h2; mem[35] = 32'h3;
        mem[36] = 32'h00000213;
        for (int i = 0; i < 16; i++) mem[37 + i] = FLT[15 - i];
        mem[53] = 32'h00000003; mem[54] = 32'h4; mem[55] = 32'h5; mem[56] = 32'h6;
        mem[57] = 32'h000000FF;
        run(32'h80, 26, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1);
    end

endmodule
